// File: rtl/life_gen_scheduler.sv
// Game-of-Life generation scheduler: paces launches, handshakes with the datapath and commits in
// vblank. Optional compute watchdog is compiled in with `define LIFE_SCHED_TIMEOUT_EN.
module life_gen_scheduler #(
  parameter int unsigned SPEED_W   = 3,
  parameter int unsigned GEN_CNT_W = 16
`ifdef LIFE_SCHED_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT   = 4096
`endif
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_run,
  input  logic                 i_step_req,
  input  logic                 i_clear_req,
  input  logic [SPEED_W-1:0]   i_speed,
  input  logic                 i_frame_tick,
  input  logic                 i_in_vblank,
  input  logic                 i_gen_done,
  output logic                 o_gen_start,
  output logic                 o_commit,
  output logic                 o_clear,
  output logic                 o_busy,
  output logic [GEN_CNT_W-1:0] o_gen_count,
  output logic                 o_err
);

  // Frame counter must reach 2**(2**SPEED_W - 1) - 1.
  localparam int unsigned FCNT_W = (1 << SPEED_W) - 1;

  typedef enum logic [1:0] {StIdle, StCompute, StWaitVb, StCommit} state_e;

  state_e               r_state;
  logic                 r_step_q;
  logic [FCNT_W-1:0]    r_fcnt;
  logic                 r_gen_start;
  logic                 r_commit;
  logic                 r_clear;
  logic                 r_busy;
  logic [GEN_CNT_W-1:0] r_gen_count;

  logic [FCNT_W-1:0]    w_fcnt_max;
  logic                 w_fcnt_last;
  logic                 w_run_launch;
  logic                 w_step_launch;
  logic                 w_done;
  logic                 w_timeout;

  assign w_fcnt_max    = FCNT_W'((32'd1 << i_speed) - 32'd1);
  assign w_fcnt_last   = (r_fcnt == w_fcnt_max);
  assign w_run_launch  = i_run & i_frame_tick & w_fcnt_last;
  assign w_step_launch = ~i_run & i_step_req & ~r_step_q;
  // A done in the gen_start cycle is too early to belong to this generation.
  assign w_done        = i_gen_done & ~r_gen_start;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= StIdle;
      r_step_q    <= 1'b0;
      r_fcnt      <= '0;
      r_gen_start <= 1'b0;
      r_commit    <= 1'b0;
      r_clear     <= 1'b0;
      r_busy      <= 1'b0;
      r_gen_count <= '0;
    end else begin
      r_step_q    <= i_step_req;
      r_gen_start <= 1'b0;
      r_commit    <= 1'b0;
      r_clear     <= 1'b0;
      if (!i_run) begin
        r_fcnt <= '0;
      end
      unique case (r_state)
        StIdle: begin
          if (i_run && i_frame_tick) begin
            r_fcnt <= w_fcnt_last ? '0 : r_fcnt + FCNT_W'(1);
          end
          if (i_clear_req) begin
            r_clear     <= 1'b1;
            r_gen_count <= '0;
          end else if (w_run_launch || w_step_launch) begin
            r_state     <= StCompute;
            r_gen_start <= 1'b1;
            r_busy      <= 1'b1;
          end
        end
        StCompute: begin
          if (w_done) begin
            if (i_in_vblank) begin
              r_state     <= StCommit;
              r_commit    <= 1'b1;
              r_gen_count <= r_gen_count + GEN_CNT_W'(1);
            end else begin
              r_state <= StWaitVb;
            end
          end else if (w_timeout) begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
          end
        end
        StWaitVb: begin
          if (i_in_vblank) begin
            r_state     <= StCommit;
            r_commit    <= 1'b1;
            r_gen_count <= r_gen_count + GEN_CNT_W'(1);
          end
        end
        StCommit: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef LIFE_SCHED_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

  logic [TO_W-1:0] r_to_cnt;
  logic            r_err;

  assign w_timeout = (r_to_cnt == TO_W'(TIMEOUT - 1));

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_to_cnt <= '0;
      r_err    <= 1'b0;
    end else begin
      r_to_cnt <= (r_state == StCompute) ? r_to_cnt + TO_W'(1) : '0;
      if ((r_state == StCompute) && !w_done && w_timeout) begin
        r_err <= 1'b1;
      end
    end
  end

  assign o_err = r_err;
`else
  assign w_timeout = 1'b0;
  assign o_err     = 1'b0;
`endif

  assign o_gen_start = r_gen_start;
  assign o_commit    = r_commit;
  assign o_clear     = r_clear;
  assign o_busy      = r_busy;
  assign o_gen_count = r_gen_count;

endmodule

// File: tb/tb_life_gen_scheduler.sv
// Bench for life_gen_scheduler: directed scenarios plus random traffic, every cycle compared
// against a behavioural model of the launch / handshake / vblank-commit rules.
module tb_life_gen_scheduler;
  localparam int unsigned SPEED_W   = 3;
  localparam int unsigned GEN_CNT_W = 8;
  localparam int unsigned TIMEOUT   = 16;
  localparam int          FMOD      = 1 << ((1 << SPEED_W) - 1);
  localparam int          CMOD      = 1 << GEN_CNT_W;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic run = 1'b0, step_req = 1'b0, clear_req = 1'b0;
  logic [SPEED_W-1:0] speed = '0;
  logic frame_tick = 1'b0, in_vblank = 1'b0, gen_done = 1'b0;
  logic gen_start, commit, clear, busy, err;
  logic [GEN_CNT_W-1:0] gen_count;

  life_gen_scheduler #(
    .SPEED_W  (SPEED_W),
    .GEN_CNT_W(GEN_CNT_W)
`ifdef LIFE_SCHED_TIMEOUT_EN
    ,
    .TIMEOUT  (TIMEOUT)
`endif
  ) dut (
    .i_clk       (clk),
    .i_reset_n   (reset_n),
    .i_run       (run),
    .i_step_req  (step_req),
    .i_clear_req (clear_req),
    .i_speed     (speed),
    .i_frame_tick(frame_tick),
    .i_in_vblank (in_vblank),
    .i_gen_done  (gen_done),
    .o_gen_start (gen_start),
    .o_commit    (commit),
    .o_clear     (clear),
    .o_busy      (busy),
    .o_gen_count (gen_count),
    .o_err       (err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  // Reference model: a generation is "in flight" from launch until commit; a computed result
  // may be waiting for vblank; the commit cycle itself is still busy.
  bit m_in_flight, m_result_ready, m_committing, m_prev_step, m_err;
  int m_frames, m_age, m_count;
  bit e_start, e_commit, e_clear;

  function automatic void model_reset();
    m_in_flight = 0; m_result_ready = 0; m_committing = 0; m_prev_step = 0; m_err = 0;
    m_frames = 0; m_age = 0; m_count = 0;
    e_start = 0; e_commit = 0; e_clear = 0;
  endfunction

  function automatic void model_commit();
    e_commit       = 1;
    m_count        = (m_count + 1) % CMOD;
    m_in_flight    = 0;
    m_result_ready = 0;
    m_committing   = 1;
  endfunction

  // Predicts outputs after the next rising edge from the inputs currently applied.
  function automatic void model_step();
    bit step_edge, frame_due;
    e_start = 0; e_commit = 0; e_clear = 0;
    step_edge   = step_req && !m_prev_step;
    m_prev_step = step_req;
    if (m_committing) begin
      m_committing = 0;
    end else if (!m_in_flight) begin
      frame_due = run && frame_tick && (m_frames == (1 << speed) - 1);
      if (run && frame_tick) m_frames = frame_due ? 0 : (m_frames + 1) % FMOD;
      if (clear_req) begin
        e_clear = 1;
        m_count = 0;
      end else if (frame_due || (!run && step_edge)) begin
        e_start        = 1;
        m_in_flight    = 1;
        m_result_ready = 0;
        m_age          = 0;
      end
    end else if (!m_result_ready) begin
      if (gen_done && m_age > 0) begin
        if (in_vblank) model_commit();
        else m_result_ready = 1;
      end
`ifdef LIFE_SCHED_TIMEOUT_EN
      else if (m_age == TIMEOUT - 1) begin
        m_err       = 1;
        m_in_flight = 0;
      end
`endif
      m_age++;
    end else if (in_vblank) begin
      model_commit();
    end
    if (!run) m_frames = 0;
  endfunction

  task automatic cycle();
    model_step();
    @(negedge clk);
    check_eq("gen_start", gen_start, e_start);
    check_eq("commit", commit, e_commit);
    check_eq("clear", clear, e_clear);
    check_eq("busy", busy, m_in_flight || m_committing);
    check_eq("gen_count", gen_count, m_count);
    check_eq("err", err, m_err);
  endtask

  // Asserts reset mid-cycle and checks outputs clear before any clock edge.
  task automatic apply_reset();
    #2 reset_n = 1'b0;
    #1;
    check_eq("rst_gen_start", gen_start, 0);
    check_eq("rst_commit", commit, 0);
    check_eq("rst_clear", clear, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_gen_count", gen_count, 0);
    check_eq("rst_err", err, 0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic step_generation();
    step_req = 0; cycle();
    step_req = 1; cycle();
    cycle();
    gen_done = 1; in_vblank = 1; cycle();
    gen_done = 0; cycle();
    cycle();
    in_vblank = 0; step_req = 0;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    apply_reset();

    // Single step: done 10 cycles after launch, vblank arrives 50 cycles later.
    step_req = 1; cycle();
    for (int i = 1; i < 10; i++) cycle();
    gen_done = 1; cycle();
    gen_done = 0;
    for (int i = 0; i < 50; i++) cycle();
    in_vblank = 1;
    for (int i = 0; i < 3; i++) cycle();
    in_vblank = 0;
    check_eq("t2_count", gen_count, 1);

    // Reset in the middle of a computation, then relaunch with a fresh edge.
    step_req = 0; cycle();
    step_req = 1; cycle();
    cycle(); cycle();
    apply_reset();
    step_req = 0; cycle();
    step_req = 1; cycle();
    cycle();
    gen_done = 1; in_vblank = 1; cycle();
    gen_done = 0; cycle(); cycle();
    in_vblank = 0;
    check_eq("t1_count", gen_count, 1);

    // Free run at speed 2: one generation per four frame ticks.
    clear_req = 1; cycle();
    clear_req = 0; step_req = 0;
    run = 1; speed = 2; in_vblank = 1;
    for (int t = 0; t < 16; t++) begin
      for (int c = 0; c < 8; c++) begin
        frame_tick = (c == 0);
        gen_done   = (c == 2);
        cycle();
      end
    end
    frame_tick = 0; gen_done = 0;
    check_eq("t3_count", gen_count, 4);
    run = 0; in_vblank = 0; cycle();

    // Clear beats a simultaneous step edge; an edge during compute is dropped.
    step_req = 0; cycle();
    step_req = 1; clear_req = 1; cycle();
    clear_req = 0; cycle();
    check_eq("t4_clear_count", gen_count, 0);
    step_req = 0; cycle();
    step_req = 1; cycle();
    step_req = 0; cycle();
    step_req = 1; cycle();
    gen_done = 1; in_vblank = 1; cycle();
    gen_done = 0; cycle(); cycle(); cycle();
    in_vblank = 0; step_req = 0;
    check_eq("t4_count", gen_count, 1);

    // Counter wrap, then stray gen_done pulses while idle.
    clear_req = 1; cycle();
    clear_req = 0;
    for (int i = 0; i < CMOD - 1; i++) step_generation();
    check_eq("t5_count_max", gen_count, CMOD - 1);
    step_generation();
    check_eq("t5_count_wrap", gen_count, 0);
    in_vblank = 1; gen_done = 1;
    for (int i = 0; i < 5; i++) cycle();
    gen_done = 0; in_vblank = 0;
    check_eq("t5_idle_done", gen_count, 0);

    // Random traffic.
    for (int seg = 0; seg < 15; seg++) begin
      run   = ($urandom_range(0, 2) != 0);
      speed = SPEED_W'($urandom_range(0, 2));
      for (int c = 0; c < 200; c++) begin
        step_req   = $urandom_range(0, 1) == 1;
        clear_req  = $urandom_range(0, 24) == 0;
        frame_tick = $urandom_range(0, 2) == 0;
        in_vblank  = $urandom_range(0, 2) == 0;
        gen_done   = $urandom_range(0, 4) == 0;
        cycle();
      end
    end
    run = 0; step_req = 0; clear_req = 0; frame_tick = 0; in_vblank = 0; gen_done = 0;
    cycle();

`ifdef LIFE_SCHED_TIMEOUT_EN
    // Launch and never answer: watchdog fires, no commit, count kept.
    apply_reset();
    step_req = 1; cycle();
    for (int i = 0; i < 20; i++) cycle();
    check_eq("t6_err", err, 1);
    check_eq("t6_busy", busy, 0);
    check_eq("t6_count", gen_count, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
